// File: rtl/uart_byte_streamer_pkg.sv
// Shared definitions for the UART byte streamer and its neighbours in the frame path.
package uart_byte_streamer_pkg;

    typedef enum logic [1:0] {
        UBS_IDLE   = 2'd0,
        UBS_STROBE = 2'd1,
        UBS_HOLD   = 2'd2,
        UBS_WAIT   = 2'd3
    } ubs_state_t;

    // End-of-frame marker appended by frame_end_stuffer, sent LSB byte first.
    localparam logic [31:0] UBS_FRAME_DELIMITER = 32'hf00f_ba11;

endpackage

// File: rtl/uart_byte_streamer_sync_byte_fifo.sv
// Byte FIFO with registered-read RAM, extra-MSB pointers and drop-on-full detection.
module sync_byte_fifo #(
    parameter int unsigned depth = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_valid,
    input  logic [7:0]              wr_data,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    empty,
    output logic                    drop,
    output logic [$clog2(depth):0]  fill_level
);

    localparam int unsigned AW = $clog2(depth);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [depth];
    logic        full;
    logic        wr_fire;
    logic        rd_fire;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Both use the pre-cycle full flag, so a write against a full FIFO drops even if a pop coincides.
    assign wr_fire    = wr_valid && !full;
    assign drop       = wr_valid && full;
    assign rd_fire    = rd_en && !empty;
    assign fill_level = wr_ptr - rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (rd_fire) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // No reset on the array or read register so the RAM maps onto block memory.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
        if (rd_fire) rd_data <= mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/uart_byte_streamer.sv
// Buffers the frame byte stream and meters it into uart_tx via its strobe/busy handshake.
module uart_byte_streamer
    import uart_byte_streamer_pkg::*;
#(
    parameter int unsigned depth       = 1024,
    parameter int unsigned count_width = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    data_in_valid,
    input  logic [7:0]              data_in,
    input  logic                    uart_busy,
    output logic                    uart_strobe,
    output logic [7:0]              uart_data,
    output logic [$clog2(depth):0]  fill_level,
    output logic                    overflow,
    input  logic                    overflow_clear,
    output logic [count_width-1:0]  dropped_count
);

    ubs_state_t state;
    ubs_state_t state_next;
    logic       pop;
    logic       empty;
    logic       drop;
    logic       loaded;
    logic [7:0] fifo_q;

    sync_byte_fifo #(
        .depth(depth)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .wr_valid   (data_in_valid),
        .wr_data    (data_in),
        .rd_en      (pop),
        .rd_data    (fifo_q),
        .empty      (empty),
        .drop       (drop),
        .fill_level (fill_level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= UBS_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            UBS_IDLE: begin
                if (!empty && !uart_busy) begin
                    pop        = 1'b1;
                    state_next = UBS_STROBE;
                end
            end
            UBS_STROBE: state_next = UBS_HOLD;
            UBS_HOLD:   state_next = UBS_WAIT;
            UBS_WAIT:   if (!uart_busy) state_next = UBS_IDLE;
            default:    state_next = UBS_IDLE;
        endcase
    end

    assign uart_strobe = (state == UBS_STROBE);

    // The RAM read register cannot be reset, so mask it until the first pop after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   loaded <= 1'b0;
        else if (pop) loaded <= 1'b1;
    end

    assign uart_data = loaded ? fifo_q : 8'h00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else if (overflow_clear) begin
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropped_count != '1) dropped_count <= dropped_count + {{(count_width-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_uart_byte_streamer.sv
// Directed bench: a large instance for ordering/latency/reset, a depth-8 instance for overflow behaviour.
module tb_uart_byte_streamer;
    import uart_byte_streamer_pkg::*;

    logic        clock;
    logic        rst_n;

    logic        a_valid, a_busy, a_clear, a_strobe, a_ovf;
    logic [7:0]  a_data, a_udata;
    logic [10:0] a_fill;
    logic [15:0] a_drop;

    logic        b_valid, b_busy, b_clear, b_strobe, b_ovf;
    logic [7:0]  b_data, b_udata;
    logic [3:0]  b_fill;
    logic [3:0]  b_drop;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int a_len = 5, b_len = 4;
    int a_cnt = 0, b_cnt = 0;
    logic b_force = 1'b0;
    int a_last = -1, b_last = -1;
    int a_expect_cyc = -1;
    int a_strobes = 0, b_strobes = 0;
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [7:0] a_exp, b_exp;

    uart_byte_streamer u_big (
        .clock          (clock),
        .reset          (rst_n),
        .data_in_valid  (a_valid),
        .data_in        (a_data),
        .uart_busy      (a_busy),
        .uart_strobe    (a_strobe),
        .uart_data      (a_udata),
        .fill_level     (a_fill),
        .overflow       (a_ovf),
        .overflow_clear (a_clear),
        .dropped_count  (a_drop)
    );

    uart_byte_streamer #(
        .depth       (8),
        .count_width (4)
    ) u_small (
        .clock          (clock),
        .reset          (rst_n),
        .data_in_valid  (b_valid),
        .data_in        (b_data),
        .uart_busy      (b_busy),
        .uart_strobe    (b_strobe),
        .uart_data      (b_udata),
        .fill_level     (b_fill),
        .overflow       (b_ovf),
        .overflow_clear (b_clear),
        .dropped_count  (b_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // uart_tx stand-in: busy rises the cycle after a strobe and lasts *_len cycles.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 0;
            b_cnt <= 0;
        end else begin
            if (a_strobe)       a_cnt <= a_len;
            else if (a_cnt > 0) a_cnt <= a_cnt - 1;
            if (b_strobe)       b_cnt <= b_len;
            else if (b_cnt > 0) b_cnt <= b_cnt - 1;
        end
    end
    assign a_busy = (a_cnt != 0);
    assign b_busy = b_force || (b_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n && a_strobe) begin
            a_strobes++;
            check("a_no_strobe_while_busy", {31'd0, a_busy}, 0);
            if (a_last >= 0) check("a_strobe_spacing", {31'd0, (cyc - a_last) >= a_len + 3}, 1);
            a_last = cyc;
            if (a_expect_cyc >= 0) begin
                check("a_latency", cyc, a_expect_cyc);
                a_expect_cyc = -1;
            end
            check("a_strobe_expected", {31'd0, a_q.size() != 0}, 1);
            if (a_q.size() != 0) begin
                a_exp = a_q.pop_front();
                check("a_uart_data", {24'd0, a_udata}, {24'd0, a_exp});
            end
        end
        if (rst_n && b_strobe) begin
            b_strobes++;
            check("b_no_strobe_while_busy", {31'd0, b_busy}, 0);
            if (b_last >= 0) check("b_strobe_spacing", {31'd0, (cyc - b_last) >= b_len + 3}, 1);
            b_last = cyc;
            check("b_strobe_expected", {31'd0, b_q.size() != 0}, 1);
            if (b_q.size() != 0) begin
                b_exp = b_q.pop_front();
                check("b_uart_data", {24'd0, b_udata}, {24'd0, b_exp});
            end
        end
    end

    task automatic a_write(input logic [7:0] d);
        a_valid = 1'b1;
        a_data  = d;
        a_q.push_back(d);
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    task automatic b_write(input logic [7:0] d, input bit accepted);
        b_valid = 1'b1;
        b_data  = d;
        if (accepted) b_q.push_back(d);
        @(negedge clock);
        b_valid = 1'b0;
    endtask

    task automatic a_drain(input int budget);
        int n = 0;
        while ((a_q.size() != 0 || a_fill != 0 || a_busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (a_len + 6) @(negedge clock);
        check("a_drain_queue", a_q.size(), 0);
        check("a_drain_fill", {21'd0, a_fill}, 0);
    endtask

    task automatic b_drain(input int budget);
        int n = 0;
        while ((b_q.size() != 0 || b_fill != 0 || b_busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (b_len + 6) @(negedge clock);
        check("b_drain_queue", b_q.size(), 0);
        check("b_drain_fill", {28'd0, b_fill}, 0);
    endtask

    task automatic b_pulse_clear();
        b_clear = 1'b1;
        @(negedge clock);
        b_clear = 1'b0;
        check("b_clear_overflow", {31'd0, b_ovf}, 0);
        check("b_clear_count", {28'd0, b_drop}, 0);
    endtask

    initial begin
        int n0;
        int n;
        logic [31:0] delim;

        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0; a_clear = 1'b0;
        b_valid = 1'b0; b_data = '0; b_clear = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_a_strobe", {31'd0, a_strobe}, 0);
        check("rst_a_data", {24'd0, a_udata}, 0);
        check("rst_a_fill", {21'd0, a_fill}, 0);
        check("rst_a_overflow", {31'd0, a_ovf}, 0);
        check("rst_a_dropped", {16'd0, a_drop}, 0);
        check("rst_b_fill", {28'd0, b_fill}, 0);
        check("rst_b_overflow", {31'd0, b_ovf}, 0);
        rst_n = 1'b1;
        @(negedge clock);

        // single byte, long busy
        a_len = 20; a_last = -1; n0 = a_strobes;
        a_expect_cyc = cyc + 2;
        a_write(8'hA5);
        a_drain(200);
        check("single_strobe_count", a_strobes - n0, 1);

        // back-to-back burst
        a_len = 5; a_last = -1; n0 = a_strobes;
        for (int i = 0; i < 16; i++) a_write(8'(i));
        check("burst_fill_peak", {31'd0, a_fill >= 11'd14}, 1);
        a_drain(400);
        check("burst_strobe_count", a_strobes - n0, 16);

        // pixels followed by the frame delimiter, LSB byte first
        a_len = 3; a_last = -1; n0 = a_strobes;
        delim = UBS_FRAME_DELIMITER;
        for (int i = 0; i < 6; i++) a_write(8'h80 + 8'(i * 7));
        for (int i = 0; i < 4; i++) a_write(delim[8*i +: 8]);
        a_drain(300);
        check("delim_strobe_count", a_strobes - n0, 10);

        // overflow with the UART held busy
        b_force = 1'b1;
        for (int i = 0; i < 12; i++) b_write(8'h40 + 8'(i), i < 8);
        check("ovf_fill", {28'd0, b_fill}, 8);
        check("ovf_flag", {31'd0, b_ovf}, 1);
        check("ovf_dropped", {28'd0, b_drop}, 4);
        b_force = 1'b0;
        b_drain(300);
        check("ovf_sticky", {31'd0, b_ovf}, 1);
        b_pulse_clear();

        // pop and write on the same cycle while full
        b_force = 1'b1;
        for (int i = 0; i < 8; i++) b_write(8'h50 + 8'(i), 1'b1);
        check("simul_full_fill", {28'd0, b_fill}, 8);
        b_force = 1'b0;
        b_write(8'hEE, 1'b0);
        check("simul_fill_after", {28'd0, b_fill}, 7);
        check("simul_dropped", {28'd0, b_drop}, 1);
        check("simul_overflow", {31'd0, b_ovf}, 1);
        b_drain(300);
        b_pulse_clear();

        // dropped counter saturation and clear-over-drop priority
        b_force = 1'b1;
        for (int i = 0; i < 8; i++) b_write(8'h60 + 8'(i), 1'b1);
        for (int i = 0; i < 14; i++) b_write(8'hD0 + 8'(i), 1'b0);
        check("sat_dropped_14", {28'd0, b_drop}, 14);
        for (int i = 14; i < 20; i++) b_write(8'hD0 + 8'(i), 1'b0);
        check("sat_dropped_20", {28'd0, b_drop}, 15);
        b_valid = 1'b1; b_data = 8'hCC; b_clear = 1'b1;
        @(negedge clock);
        b_valid = 1'b0; b_clear = 1'b0;
        check("prio_overflow", {31'd0, b_ovf}, 0);
        check("prio_dropped", {28'd0, b_drop}, 0);
        check("prio_fill", {28'd0, b_fill}, 8);
        b_force = 1'b0;
        b_drain(300);

        // asynchronous reset in the middle of a strobe
        a_len = 10; a_last = -1;
        a_write(8'h77);
        a_write(8'h78);
        a_write(8'h79);
        n = 0;
        while (!a_strobe && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("arst_strobe_seen", {31'd0, a_strobe}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_strobe_low", {31'd0, a_strobe}, 0);
        check("arst_fill_zero", {21'd0, a_fill}, 0);
        check("arst_data_zero", {24'd0, a_udata}, 0);
        a_q.delete();
        b_q.delete();
        a_last = -1; b_last = -1;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        n0 = a_strobes;
        a_expect_cyc = cyc + 2;
        a_write(8'h3C);
        a_drain(100);
        check("arst_single_strobe", a_strobes - n0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_byte_streamer.md
Name: uart_byte_streamer

Overview:
- Sits downstream of frame_end_stuffer and upstream of uart_tx.
- Absorbs the bursty byte stream (image bytes plus the 4-byte 0xf00fba11 end-of-frame delimiter) into a FIFO.
- Drains the FIFO one byte at a time through uart_tx's strobe/busy handshake.
- Counts and flags bytes lost to overflow so host-side frame-alignment failures can be diagnosed.

Parameters:
- depth, 1024: FIFO depth in bytes; must be a power of two, at least 4.
- count_width, 16: width of the dropped-byte counter.

Ports:
- clock  input  1  system clock (osc_12m domain).
- reset  input  1  asynchronous, active-low reset.
- data_in_valid  input  1  one-cycle qualifier for data_in.
- data_in  input  8  byte from frame_end_stuffer.
- uart_busy  input  1  high while uart_tx is shifting a byte.
- uart_strobe  output  1  one-cycle pulse; uart_tx samples uart_data on this cycle.
- uart_data  output  8  byte presented to uart_tx.
- fill_level  output  $clog2(depth)+1  current FIFO occupancy.
- overflow  output  1  sticky; set on the first dropped byte.
- overflow_clear  input  1  synchronous clear of overflow and dropped_count.
- dropped_count  output  count_width  saturating count of dropped bytes.

Behaviour:
- Reset (reset low, asynchronous): pointers are 0; fill_level 0; uart_strobe 0; uart_data 8'h00; overflow 0; dropped_count 0; FSM goes to IDLE. FIFO RAM contents are don't-care.
- Write side:
  - On data_in_valid with fill_level < depth, data_in is written at wr_ptr and wr_ptr increments modulo depth.
  - On data_in_valid with a full FIFO, the byte is discarded, overflow is set, and dropped_count increments, saturating at all-ones.
- Pointers are $clog2(depth)+1 bits wide. Full means MSBs differ and the rest are equal. Empty means the pointers are equal. fill_level = wr_ptr - rd_ptr.
- Simultaneous write and read on the same cycle is permitted, including when the FIFO is full: the read pops in that cycle but the write is evaluated against the pre-cycle full status. A write arriving while full is therefore dropped even if a read pops the same cycle, and fill_level stays depth-1 after that cycle.
- overflow_clear takes priority over a same-cycle drop: both fields read 0 the next cycle.
- FSM states:
  - IDLE: when the FIFO is non-empty and uart_busy is 0, pop the head byte into the uart_data register and go to STROBE.
  - STROBE: uart_strobe = 1 for exactly this cycle, with uart_data stable. Go to HOLD.
  - HOLD: one guard cycle covering uart_tx's one-cycle busy assertion latency. Go to WAIT.
  - WAIT: stay while uart_busy is 1. When it is 0, go to IDLE.
- Latency: a byte written into an empty FIFO, with the UART idle, produces uart_strobe 2 cycles after data_in_valid. That is write cycle, then IDLE pops the next cycle, then STROBE.
- Byte order out equals byte order in. No byte is duplicated or reordered.
- uart_data holds its last value outside STROBE.
- Reset asserted mid-transfer aborts immediately; uart_strobe is never left high. The byte in flight is lost by design.
- FIFO memory is a registered-read array. It must infer iCE40 BRAM for depth ≥ 256; the read address is registered in IDLE.

Decomposition:
- A shared package/include holds:
  - the FSM state encodings (UBS_IDLE=2'd0, UBS_STROBE=2'd1, UBS_HOLD=2'd2, UBS_WAIT=2'd3);
  - the delimiter constant 32'hf00f_ba11 shared with frame_end_stuffer.
- One sub-module, sync_byte_fifo. It contains the RAM, pointers, full/empty/fill_level and the drop logic. It is parameterised by depth and reused by the future SPI offload path.
- The top level holds the UART handshake FSM and the overflow counters.

Test Plan:
- Single byte: after reset, write 8'hA5 once, uart_busy model 20 cycles long → exactly one uart_strobe, with uart_data=8'hA5, 2 cycles after the write; fill_level returns to 0.
- Burst ordering: write 0x00..0x0F back-to-back (16 cycles) → 16 strobes, uart_data 0x00..0x0F in order, each strobe spaced ≥ busy length + 3 cycles; no strobe while busy is high.
- Overflow, depth=8, UART held busy: write 12 bytes → fill_level=8, overflow=1, dropped_count=4. Release busy → first 8 bytes emerge in order. Pulse overflow_clear → overflow=0, dropped_count=0.
- Simultaneous full write/read, depth=8: FIFO full, release busy so a pop coincides with a write → incoming byte dropped, dropped_count+1, fill_level 7 the next cycle.
- Saturation, count_width=4: 20 drops → dropped_count=4'hF, with no wrap.
- Async reset: assert reset low during STROBE, between clock edges → uart_strobe and fill_level go to 0 without a clock edge; after release, writing 8'h3C yields a single correct strobe.
- Frame delimiter pass-through: feed 6 pixel bytes then bytes 0x11,0xba,0x0f,0xf0 → UART stream reproduces all 10 bytes in that order.
